// File: rtl/game_ctrl.sv
// game_ctrl: falling-block game controller (FSM, key edges, gravity timer, piece RNG, score/level)
module game_ctrl #(
    parameter int GRAVITY_INIT = 1000,
    parameter int GRAVITY_STEP = 64,
    parameter int GRAVITY_MIN  = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_down,
    input  logic        btn_rot,
    input  logic        next_block,
    input  logic [9:0]  score_plus,
    input  logic        gameover,
    output logic        left,
    output logic        right,
    output logic        down,
    output logic [9:0]  ro,
    output logic [9:0]  block_num,
    output logic [15:0] score,
    output logic [3:0]  level,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
    state_t             r_state, w_next;
    logic [4:0]         r_prev;
    logic               w_start_e, w_left_e, w_right_e, w_down_e, w_rot_e;
    logic               w_play, w_enter, w_move, w_expire, w_load, w_fb;
    logic               r_left, r_right, r_down;
    logic [1:0]         r_ro;
    logic [2:0]         r_blk;
    logic [15:0]        r_score, r_lfsr;
    logic [16:0]        w_sum;
    logic [31:0]        r_grav;
    logic signed [31:0] w_raw, w_period;

    assign {w_start_e, w_left_e, w_right_e, w_down_e, w_rot_e} =
        {start, btn_left, btn_right, btn_down, btn_rot} & ~r_prev;
    assign w_play  = r_state == PLAY;
    assign w_enter = r_state == IDLE && w_start_e;
    assign w_move  = w_play && !gameover;
    assign w_load  = w_enter || (w_play && next_block);
    assign w_sum   = {1'b0, r_score} + {7'd0, score_plus};
    assign w_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign level    = (r_score[15:12] != 4'd0) ? 4'd15 : r_score[11:8];
    assign w_raw    = GRAVITY_INIT - $signed({28'd0, level}) * GRAVITY_STEP;
    assign w_period = (w_raw < GRAVITY_MIN) ? GRAVITY_MIN : w_raw;
    // >= rather than == so a period shrinking below the running count still expires at once
    assign w_expire = w_play && (r_grav >= $unsigned(w_period - 1));
    assign left      = r_left;
    assign right     = r_right;
    assign down      = r_down;
    assign ro        = {8'd0, r_ro};
    assign block_num = {7'd0, r_blk};
    assign score     = r_score;
    assign state     = r_state;

    // next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_e) w_next = PLAY;
            PLAY:    if (gameover) w_next = OVER;
            OVER:    if (w_start_e) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state register, key history for edge detection, free-running LFSR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_prev  <= 5'd0;
            r_lfsr  <= 16'hACE1;
        end else begin
            r_state <= w_next;
            r_prev  <= {start, btn_left, btn_right, btn_down, btn_rot};
            r_lfsr  <= {w_fb, r_lfsr[15:1]};
        end
    end

    // move pulses; opposing left/right edges cancel, key and gravity drops merge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_left  <= w_move && w_left_e && !w_right_e;
            r_right <= w_move && w_right_e && !w_left_e;
            r_down  <= w_move && (w_down_e || w_expire);
        end
    end

    // rotation, piece id and saturating score; a new piece resets rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ro    <= 2'd0;
            r_blk   <= 3'd0;
            r_score <= 16'd0;
        end else begin
            r_ro    <= w_load ? 2'd0 : (w_play && w_rot_e) ? r_ro + 2'd1 : r_ro;
            r_blk   <= !w_load ? r_blk : (r_lfsr[2:0] == 3'd7) ? 3'd0 : r_lfsr[2:0];
            r_score <= w_enter ? 16'd0 : !(w_play && next_block) ? r_score :
                       w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    // gravity counter: runs only in PLAY, restarts on a new piece or a new game
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_grav <= 32'd0;
        else if (w_enter)
            r_grav <= 32'd0;
        else if (w_play)
            r_grav <= (next_block || w_expire) ? 32'd0 : r_grav + 32'd1;
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed and random stimulus against a behavioural model of game_ctrl
module tb_game_ctrl;
    localparam int G_INIT = 1000, G_STEP = 64, G_MIN = 128;
    logic clk = 0, rst_n = 1, start = 0;
    logic btn_left = 0, btn_right = 0, btn_down = 0, btn_rot = 0;
    logic next_block = 0, gameover = 0;
    logic [9:0] score_plus = 0;
    logic left, right, down;
    logic [9:0] ro, block_num;
    logic [15:0] score;
    logic [3:0] level;
    logic [1:0] state;
    int n_vec = 0, n_bad = 0;
    int m_state, m_ro, m_blk, m_score, m_cnt, m_lfsr;
    bit m_left, m_right, m_down;
    bit p_start, p_left, p_right, p_down, p_rot;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down), .btn_rot(btn_rot),
        .next_block(next_block), .score_plus(score_plus), .gameover(gameover),
        .left(left), .right(right), .down(down), .ro(ro), .block_num(block_num),
        .score(score), .level(level), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_level();
        return (m_score / 256 > 15) ? 15 : m_score / 256;
    endfunction

    function automatic int model_period();
        int p = G_INIT - model_level() * G_STEP;
        return (p < G_MIN) ? G_MIN : p;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ro = 0; m_blk = 0; m_score = 0; m_cnt = 0; m_lfsr = 16'hACE1;
        m_left = 0; m_right = 0; m_down = 0;
        {p_start, p_left, p_right, p_down, p_rot} = 5'b0;
    endtask

    task automatic model_clock();
        bit se, le, re, de, rte, play, enter, mv, expd;
        int per = model_period();
        int r;
        se = start && !p_start; le = btn_left && !p_left; re = btn_right && !p_right;
        de = btn_down && !p_down; rte = btn_rot && !p_rot;
        play = m_state == 1;
        enter = m_state == 0 && se;
        mv = play && !gameover;
        expd = play && (m_cnt >= per - 1);
        m_left = mv && le && !re;
        m_right = mv && re && !le;
        m_down = mv && (de || expd);
        r = m_lfsr % 8;
        if (enter || (play && next_block)) m_blk = (r == 7) ? 0 : r;
        if (enter) begin
            m_cnt = 0; m_ro = 0; m_score = 0;
        end else if (play) begin
            m_cnt = (next_block || expd) ? 0 : m_cnt + 1;
            m_ro = next_block ? 0 : rte ? (m_ro + 1) % 4 : m_ro;
            if (next_block) m_score = (m_score + int'(score_plus) > 65535) ? 65535 : m_score + int'(score_plus);
        end
        m_state = (m_state == 0) ? (se ? 1 : 0) : (m_state == 1) ? (gameover ? 2 : 1) : (se ? 0 : 2);
        m_lfsr = (m_lfsr >> 1) | ((((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
        {p_start, p_left, p_right, p_down, p_rot} = {start, btn_left, btn_right, btn_down, btn_rot};
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("left", left, m_left);
        chk("right", right, m_right);
        chk("down", down, m_down);
        chk("ro", ro, m_ro);
        chk("block_num", block_num, m_blk);
        chk("score", score, m_score);
        chk("level", level, model_level());
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic count_down(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!down && n < 3000);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic quiet();
        {btn_left, btn_right, btn_down, btn_rot, next_block, gameover} = 6'b0;
        score_plus = 0;
    endtask

    initial begin
        int n, cnt, saved;
        #2;
        do_reset();
        cyc(3);
        // new game and default gravity timing
        start = 1; step();
        chk("play_entry", state, 1);
        chk("score_zero", score, 0);
        chk("blk_range", block_num <= 6, 1);
        count_down(n);
        chk("grav_lvl0", n, 1000);
        // held key gives one pulse; opposing edges cancel
        btn_left = 1; cnt = 0;
        repeat (50) begin step(); cnt += left; end
        chk("left_once", cnt, 1);
        btn_left = 0; step();
        btn_left = 1; btn_right = 1; cnt = 0;
        repeat (5) begin step(); cnt += left + right; end
        chk("lr_cancel", cnt, 0);
        quiet(); step();
        // rotation sequence and new-piece priority
        next_block = 1; step(); next_block = 0;
        for (int i = 1; i <= 4; i++) begin
            btn_rot = 1; step();
            chk("rot_seq", ro, i % 4);
            btn_rot = 0; step();
        end
        btn_rot = 1; step(); btn_rot = 0; step();
        chk("rot_one", ro, 1);
        btn_rot = 1; next_block = 1; step();
        chk("rot_nb", ro, 0);
        quiet(); step();
        // score saturation, level 15 gravity floor
        next_block = 1; score_plus = 1023;
        repeat (64) step();
        score_plus = 48; step();
        chk("score_fff0", score, 16'hFFF0);
        score_plus = 100; step();
        chk("score_sat", score, 16'hFFFF);
        quiet();
        chk("lvl15", level, 15);
        count_down(n);
        chk("grav_lvl15", n, 128);
        // restart through OVER/IDLE, then level 1 gravity
        gameover = 1; step(); gameover = 0;
        chk("over", state, 2);
        start = 0; step(); start = 1; step();
        chk("idle", state, 0);
        start = 0; step(); start = 1; step();
        chk("replay", state, 1);
        chk("score_clr", score, 0);
        next_block = 1; score_plus = 256; step();
        quiet();
        chk("lvl1", level, 1);
        count_down(n);
        chk("grav_lvl1", n, 936);
        // OVER ignores keys and new pieces
        gameover = 1; step(); gameover = 0;
        chk("over2", state, 2);
        saved = score; cnt = 0;
        repeat (40) begin
            btn_left = 1'($urandom); btn_right = 1'($urandom); btn_down = 1'($urandom);
            btn_rot = 1'($urandom); next_block = 1'($urandom); score_plus = 10'($urandom);
            step();
            cnt += left + right + down;
        end
        chk("over_quiet", cnt, 0);
        chk("over_score", score, saved);
        quiet();
        start = 0; step(); start = 1; step();
        chk("over_idle", state, 0);
        // reset mid-game with start held
        start = 0; step(); start = 1; step();
        cyc(20);
        do_reset();
        step();
        chk("rst_start", state, 1);
        // random play
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) start = ~start;
            if ($urandom_range(0, 2) == 0) btn_left = ~btn_left;
            if ($urandom_range(0, 2) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 2) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 2) == 0) btn_rot = ~btn_rot;
            next_block = $urandom_range(0, 9) == 0;
            gameover = $urandom_range(0, 149) == 0;
            score_plus = 10'($urandom);
            if (i == 1500) do_reset();
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter GRAVITY_INIT, default 1000, gravity period in clk cycles at level 0.
REQ-002 SHALL have parameter GRAVITY_STEP, default 64, period reduction per level.
REQ-003 SHALL have parameter GRAVITY_MIN, default 128, floor on gravity period.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  start/restart button level, pre-synchronized.
REQ-007 SHALL have ports btn_left, btn_right, btn_down, btn_rot  input  1 each  pre-synchronized key levels.
REQ-008 SHALL have port next_block  input  1  piece-locked pulse from field stage.
REQ-009 SHALL have port score_plus  input  10  points for the locked piece, valid with next_block.
REQ-010 SHALL have port gameover  input  1  field overflow flag from field stage.
REQ-011 SHALL have ports left, right, down  output  1 each  single-cycle move pulses to field stage.
REQ-012 SHALL have port ro  output  10  rotation index, range 0..3, upper bits zero.
REQ-013 SHALL have port block_num  output  10  piece id, range 0..6, upper bits zero.
REQ-014 SHALL have port score  output  16  accumulated score.
REQ-015 SHALL have port level  output  4  current level.
REQ-016 SHALL have port state  output  2  FSM state: IDLE=0, PLAY=1, OVER=2.

Function
REQ-017 SHALL implement FSM: IDLE->PLAY on start rising edge; PLAY->OVER when gameover=1; OVER->IDLE on start rising edge; encoding 3 unreachable, recovers to IDLE next cycle.
REQ-018 SHALL detect rising edges of start and all btn_* with one registered previous-value flop each; level held high yields exactly one edge.
REQ-019 SHALL drive left/right one cycle after the btn edge, PLAY only; simultaneous left and right edges SHALL both be suppressed.
REQ-020 SHALL drive down for one cycle on btn_down edge or gravity expiry; both in the same cycle SHALL give a single pulse.
REQ-021 SHALL increment ro modulo 4 (3->0) on btn_rot edge in PLAY, registered one cycle after the edge; ro SHALL clear to 0 on next_block, and next_block SHALL win over a same-cycle btn_rot edge.
REQ-022 SHALL run 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing every cycle in every state.
REQ-023 SHALL load block_num = lfsr[2:0] on next_block in PLAY and on IDLE->PLAY transition, with value 7 mapped to 0; update visible the following cycle.
REQ-024 SHALL add score_plus (zero-extended) to score on next_block in PLAY, saturating at 16'hFFFF.
REQ-025 SHALL compute level = min(15, score[15:8]) combinationally from score.
REQ-026 SHALL compute period = max(GRAVITY_MIN, GRAVITY_INIT - level*GRAVITY_STEP) using signed-safe arithmetic (no underflow wrap).
REQ-027 SHALL count gravity counter 0..period-1 in PLAY, pulse down when counter equals period-1, then reload 0.
REQ-028 SHALL clear gravity counter on next_block and on entering PLAY; counter SHALL hold in IDLE and OVER.
REQ-029 SHALL emit no left/right/down pulses and no ro/score changes outside PLAY; next_block outside PLAY SHALL be ignored.
REQ-030 SHALL clear score to 0 and ro to 0 on IDLE->PLAY transition.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE, left=right=down=0, ro=0, block_num=0, score=0, gravity counter=0, all edge flops=0, lfsr=16'hACE1, independent of clk.
REQ-032 SHALL, on reset asserted mid-PLAY, abort immediately to reset values; first edge on start after release SHALL be detected (a held start counts as a rising edge after release).

Verification
REQ-033 SHALL verify: reset release, start pulse -> state=1 next cycle, score=0, block_num in 0..6, no down pulse for 999 cycles, down pulse at cycle 1000 (defaults).
REQ-034 SHALL verify: btn_left held 50 cycles in PLAY -> exactly one left pulse; btn_left and btn_right rising same cycle -> no left, no right pulse.
REQ-035 SHALL verify: four btn_rot edges -> ro sequence 1,2,3,0; btn_rot edge coincident with next_block -> ro=0.
REQ-036 SHALL verify: score=16'hFFF0, next_block with score_plus=100 -> score=16'hFFFF; score=16'h0100 -> level=1, gravity period 936.
REQ-037 SHALL verify: score forcing level=15 -> period=GRAVITY_MIN=128 (1000-960=40 clamped).
REQ-038 SHALL verify: gameover=1 in PLAY -> state=2, subsequent btn edges and next_block produce no pulses and no score change; start edge -> state=0.
